// File: rtl/regfile_pkg.sv
// Shared constants and width helpers for the scoreboarded register file.
package regfile_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int ZERO_IDX = 0;

   function automatic int addr_w(input int nreg);
      return (nreg <= 2) ? 1 : $clog2(nreg);
   endfunction

   function automatic int cnt_w(input int nreg);
      return $clog2(nreg + 1);
   endfunction

endpackage

// File: rtl/regfile_if.sv
// Read, writeback and issue/scoreboard signals between the pipeline and the register file.
interface regfile_if
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF
);
   localparam int AW = addr_w(NREG);
   localparam int CW = cnt_w(NREG);

   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            we;
   logic [AW-1:0]   wt_addr;
   logic [XLEN-1:0] wt_data;
   logic            issue_valid;
   logic [AW-1:0]   issue_rd;
   logic            issue_ready;
   logic            flush;
   logic [CW-1:0]   busy_count;

   modport master (
      output rs1_addr, rs2_addr, we, wt_addr, wt_data, issue_valid, issue_rd, flush,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready, busy_count
   );

   modport slave (
      input  rs1_addr, rs2_addr, we, wt_addr, wt_data, issue_valid, issue_rd, flush,
      output rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready, busy_count
   );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: stored value, optional same-cycle write bypass, zero register.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREG     = NREG_DEF,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = addr_w(NREG)
) (
   input  logic [AW-1:0]   addr,
   input  logic [XLEN-1:0] store_data,
   input  logic            store_busy,
   input  logic            wr_fwd,
   input  logic [AW-1:0]   wt_addr,
   input  logic [XLEN-1:0] wt_data,
   output logic [XLEN-1:0] data,
   output logic            busy
);

   always_comb begin
      data = store_data;
      busy = store_busy;
      // A landing writeback also retires the pending bit, so the reader sees it as ready.
      if ((BYPASS != 0) && wr_fwd && (wt_addr == addr)) begin
         data = wt_data;
         busy = 1'b0;
      end
      if ((ZERO_REG != 0) && (addr == AW'(ZERO_IDX))) begin
         data = '0;
         busy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with per-register pending scoreboard and an incremental busy counter.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREG     = NREG_DEF,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic      clk,
   input  logic      rst,
   regfile_if.slave  bus
);

   localparam int AW = addr_w(NREG);
   localparam int CW = cnt_w(NREG);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] pending_q, pending_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wr_en;
   logic            iss_ready;
   logic            iss_set;

   always_comb begin
      wr_en     = bus.we && !((ZERO_REG != 0) && (bus.wt_addr == AW'(ZERO_IDX)));
      iss_ready = !bus.flush &&
                  !(pending_q[bus.issue_rd] && !(bus.we && (bus.wt_addr == bus.issue_rd)));
      iss_set   = bus.issue_valid && iss_ready &&
                  !((ZERO_REG != 0) && (bus.issue_rd == AW'(ZERO_IDX)));

      regs_d = regs_q;
      if (wr_en) regs_d[bus.wt_addr] = bus.wt_data;

      pending_d = pending_q;
      cnt_d     = cnt_q;
      if (bus.flush) begin
         pending_d = '0;
         cnt_d     = '0;
      end else begin
         // Clear before set so a same-register write+issue nets to pending=1 and count unchanged.
         if (wr_en && pending_q[bus.wt_addr]) begin
            pending_d[bus.wt_addr] = 1'b0;
            cnt_d                  = cnt_d - CW'(1);
         end
         if (iss_set) begin
            pending_d[bus.issue_rd] = 1'b1;
            cnt_d                   = cnt_d + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs_q    <= '{default: '0};
         pending_q <= '0;
         cnt_q     <= '0;
      end else begin
         regs_q    <= regs_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.issue_ready = iss_ready;
   assign bus.busy_count  = cnt_q;

   regfile_read_port #(
      .XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
   ) u_rd1 (
      .addr       (bus.rs1_addr),
      .store_data (regs_q[bus.rs1_addr]),
      .store_busy (pending_q[bus.rs1_addr]),
      .wr_fwd     (wr_en),
      .wt_addr    (bus.wt_addr),
      .wt_data    (bus.wt_data),
      .data       (bus.rs1_data),
      .busy       (bus.rs1_busy)
   );

   regfile_read_port #(
      .XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
   ) u_rd2 (
      .addr       (bus.rs2_addr),
      .store_data (regs_q[bus.rs2_addr]),
      .store_busy (pending_q[bus.rs2_addr]),
      .wr_fwd     (wr_en),
      .wt_addr    (bus.wt_addr),
      .wt_data    (bus.wt_data),
      .data       (bus.rs2_data),
      .busy       (bus.rs2_busy)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: default build (bypass), a no-bypass build and a 16x64 build.
module tb_regfile_sb;
   import regfile_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_if #(.XLEN(32), .NREG(32)) ia ();
   regfile_if #(.XLEN(32), .NREG(32)) ib ();
   regfile_if #(.XLEN(64), .NREG(16)) ic ();

   regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1), .ZERO_REG(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
   regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0), .ZERO_REG(1)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
   regfile_sb #(.XLEN(64), .NREG(16), .BYPASS(1), .ZERO_REG(1)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        iv;
      logic [4:0]  ird;
      logic        fl;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] d1;
      logic        b1;
      logic [31:0] d2;
      logic        b2;
      logic        rdy;
      int          cnt;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic iv, input logic [4:0] ird, input logic fl,
                               input logic [4:0] a1, input logic [4:0] a2,
                               input logic [31:0] d1, input logic b1,
                               input logic [31:0] d2, input logic b2,
                               input logic rdy, input int cnt);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.iv = iv; v.ird = ird; v.fl = fl;
      v.a1 = a1; v.a2 = a2; v.d1 = d1; v.b1 = b1; v.d2 = d2; v.b2 = b2;
      v.rdy = rdy; v.cnt = cnt;
      return v;
   endfunction

   function automatic logic [63:0] val64(input int i);
      return {16'hA5A5, 16'(i), 16'h5A5A, 16'(i)};
   endfunction

   vec_t tbl[$];

   initial begin
      rst = 1'b0;
      ia.we = 1'b0; ia.wt_addr = '0; ia.wt_data = '0; ia.issue_valid = 1'b0; ia.issue_rd = '0;
      ia.flush = 1'b0; ia.rs1_addr = '0; ia.rs2_addr = '0;
      ib.we = 1'b0; ib.wt_addr = '0; ib.wt_data = '0; ib.issue_valid = 1'b0; ib.issue_rd = '0;
      ib.flush = 1'b0; ib.rs1_addr = '0; ib.rs2_addr = '0;
      ic.we = 1'b0; ic.wt_addr = '0; ic.wt_data = '0; ic.issue_valid = 1'b0; ic.issue_rd = '0;
      ic.flush = 1'b0; ic.rs1_addr = '0; ic.rs2_addr = '0;

      //            we    wa      wd             iv    ird    fl    a1     a2     d1             b1    d2             b2    rdy   cnt
      tbl.push_back(mk(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 32'h12345678, 1'b0, 32'h0,        1'b0, 1'b1, 0));
      tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 32'h12345678, 1'b0, 32'h0,        1'b0, 1'b1, 0));
      tbl.push_back(mk(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd5, 32'h0,        1'b0, 32'h12345678, 1'b0, 1'b1, 0));
      tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 32'h0,        1'b0, 32'h12345678, 1'b0, 1'b1, 0));
      tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 5'd7, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1));
      tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1));
      tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 5'd0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 1));
      tbl.push_back(mk(1'b1, 5'd7, 32'hA5,       1'b1, 5'd7, 1'b0, 5'd7, 5'd7, 32'hA5,       1'b0, 32'hA5,       1'b0, 1'b1, 1));
      tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 32'hA5,       1'b1, 32'h0,        1'b0, 1'b1, 1));
      tbl.push_back(mk(1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 32'h77,       1'b0, 32'h77,       1'b0, 1'b1, 0));
      tbl.push_back(mk(1'b1, 5'd3, 32'hDEAD,     1'b0, 5'd0, 1'b0, 5'd3, 5'd3, 32'hDEAD,     1'b0, 32'hDEAD,     1'b0, 1'b1, 0));
      tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd1, 1'b0, 5'd3, 5'd1, 32'hDEAD,     1'b0, 32'h0,        1'b0, 1'b1, 1));
      tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 1'b0, 5'd1, 5'd2, 32'h0,        1'b1, 32'h0,        1'b0, 1'b1, 2));
      tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b0, 5'd3, 5'd2, 32'hDEAD,     1'b0, 32'h0,        1'b1, 1'b1, 3));
      tbl.push_back(mk(1'b1, 5'd4, 32'h44,       1'b1, 5'd4, 1'b1, 5'd1, 5'd3, 32'h0,        1'b1, 32'hDEAD,     1'b1, 1'b0, 0));
      tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd4, 5'd3, 32'h44,       1'b0, 32'hDEAD,     1'b0, 1'b1, 0));
      tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 1'b0, 5'd4, 5'd1, 32'h44,       1'b0, 32'h0,        1'b0, 1'b1, 1));
      tbl.push_back(mk(1'b1, 5'd4, 32'h99,       1'b0, 5'd0, 1'b0, 5'd4, 5'd4, 32'h99,       1'b0, 32'h99,       1'b0, 1'b1, 0));
      tbl.push_back(mk(1'b1, 5'd9, 32'h9,        1'b1, 5'd9, 1'b0, 5'd9, 5'd4, 32'h9,        1'b0, 32'h99,       1'b0, 1'b1, 1));
      tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 5'd0, 32'h9,        1'b1, 32'h0,        1'b0, 1'b1, 1));

      // Reset state
      repeat (2) @(negedge clk);
      ia.rs1_addr = 5'd5;
      #1;
      chk("rst_a_rs1_data", ia.rs1_data, 64'h0);
      chk("rst_a_rs1_busy", ia.rs1_busy, 64'h0);
      chk("rst_a_count", ia.busy_count, 64'h0);
      chk("rst_c_count", ic.busy_count, 64'h0);
      @(negedge clk);
      rst = 1'b1;

      // Table-driven main sequence on the default build
      foreach (tbl[k]) begin
         @(negedge clk);
         ia.we = tbl[k].we; ia.wt_addr = tbl[k].wa; ia.wt_data = tbl[k].wd;
         ia.issue_valid = tbl[k].iv; ia.issue_rd = tbl[k].ird; ia.flush = tbl[k].fl;
         ia.rs1_addr = tbl[k].a1; ia.rs2_addr = tbl[k].a2;
         #1;
         chk($sformatf("v%0d_rs1_data", k), ia.rs1_data, tbl[k].d1);
         chk($sformatf("v%0d_rs1_busy", k), ia.rs1_busy, tbl[k].b1);
         chk($sformatf("v%0d_rs2_data", k), ia.rs2_data, tbl[k].d2);
         chk($sformatf("v%0d_rs2_busy", k), ia.rs2_busy, tbl[k].b2);
         chk($sformatf("v%0d_ready", k), ia.issue_ready, tbl[k].rdy);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_count", k), ia.busy_count, 64'(tbl[k].cnt));
      end

      // Asynchronous reset mid-operation takes effect without a clock edge
      @(negedge clk);
      ia.we = 1'b0; ia.issue_valid = 1'b0; ia.flush = 1'b0;
      ia.rs1_addr = 5'd9;
      #2 rst = 1'b0;
      #1;
      chk("async_rst_rs1_data", ia.rs1_data, 64'h0);
      chk("async_rst_rs1_busy", ia.rs1_busy, 64'h0);
      chk("async_rst_count", ia.busy_count, 64'h0);

      // First edge after release accepts an issue
      @(negedge clk);
      rst = 1'b1;
      ia.issue_valid = 1'b1; ia.issue_rd = 5'd6; ia.rs1_addr = 5'd6;
      @(posedge clk);
      #1;
      chk("post_rst_count", ia.busy_count, 64'h1);
      chk("post_rst_busy6", ia.rs1_busy, 64'h1);
      @(negedge clk);
      ia.issue_valid = 1'b0;

      // No-bypass build: write is invisible until the next cycle
      ib.we = 1'b1; ib.wt_addr = 5'd3; ib.wt_data = 32'h1111;
      @(negedge clk);
      ib.we = 1'b0; ib.issue_valid = 1'b1; ib.issue_rd = 5'd3; ib.rs1_addr = 5'd3; ib.rs2_addr = 5'd3;
      @(posedge clk);
      #1;
      chk("nb_issue_busy", ib.rs1_busy, 64'h1);
      chk("nb_issue_count", ib.busy_count, 64'h1);
      @(negedge clk);
      ib.issue_valid = 1'b0; ib.we = 1'b1; ib.wt_addr = 5'd3; ib.wt_data = 32'hDEAD;
      #1;
      chk("nb_same_cycle_data1", ib.rs1_data, 64'h1111);
      chk("nb_same_cycle_data2", ib.rs2_data, 64'h1111);
      chk("nb_same_cycle_busy", ib.rs1_busy, 64'h1);
      @(posedge clk);
      #1;
      chk("nb_next_data", ib.rs1_data, 64'hDEAD);
      chk("nb_next_busy", ib.rs1_busy, 64'h0);
      chk("nb_next_count", ib.busy_count, 64'h0);
      @(negedge clk);
      ib.we = 1'b0;

      // 16x64 build: reserve every non-zero register
      for (int i = 1; i < 16; i++) begin
         ic.issue_valid = 1'b1; ic.issue_rd = 4'(i);
         @(posedge clk);
         #1;
         chk($sformatf("w_fill_count_%0d", i), ic.busy_count, 64'(i));
         @(negedge clk);
      end
      ic.issue_valid = 1'b1; ic.issue_rd = 4'd0;
      @(posedge clk);
      #1;
      chk("w_zero_issue_count", ic.busy_count, 64'd15);
      @(negedge clk);
      ic.issue_rd = 4'd5;
      #1;
      chk("w_waw_stall", ic.issue_ready, 64'h0);
      ic.issue_valid = 1'b0;

      for (int i = 1; i < 16; i++) begin
         ic.we = 1'b1; ic.wt_addr = 4'(i); ic.wt_data = val64(i);
         @(posedge clk);
         #1;
         chk($sformatf("w_drain_count_%0d", i), ic.busy_count, 64'(15 - i));
         @(negedge clk);
      end
      ic.we = 1'b0;

      for (int i = 0; i < 16; i++) begin
         ic.rs1_addr = 4'(i);
         #1;
         chk($sformatf("w_read_%0d", i), ic.rs1_data, (i == 0) ? 64'h0 : val64(i));
         chk($sformatf("w_busy_%0d", i), ic.rs1_busy, 64'h0);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
